// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the Mini-SRC control sequencer: opcodes, FSM states,
// instruction classes and the bit positions of the packed datapath strobes.
package cpu_ctrl_pkg;

    localparam int CTRL_W = 30;

    localparam logic [4:0] OP_LD   = 5'd0;
    localparam logic [4:0] OP_LDI  = 5'd1;
    localparam logic [4:0] OP_ST   = 5'd2;
    localparam logic [4:0] OP_ADD  = 5'd3;
    localparam logic [4:0] OP_SUB  = 5'd4;
    localparam logic [4:0] OP_AND  = 5'd5;
    localparam logic [4:0] OP_OR   = 5'd6;
    localparam logic [4:0] OP_ROR  = 5'd7;
    localparam logic [4:0] OP_ROL  = 5'd8;
    localparam logic [4:0] OP_SHR  = 5'd9;
    localparam logic [4:0] OP_SHL  = 5'd10;
    localparam logic [4:0] OP_ADDI = 5'd11;
    localparam logic [4:0] OP_ANDI = 5'd12;
    localparam logic [4:0] OP_ORI  = 5'd13;
    localparam logic [4:0] OP_MUL  = 5'd14;
    localparam logic [4:0] OP_DIV  = 5'd15;
    localparam logic [4:0] OP_NEG  = 5'd16;
    localparam logic [4:0] OP_NOT  = 5'd17;
    localparam logic [4:0] OP_BR   = 5'd18;
    localparam logic [4:0] OP_JR   = 5'd19;
    localparam logic [4:0] OP_JAL  = 5'd20;
    localparam logic [4:0] OP_IN   = 5'd21;
    localparam logic [4:0] OP_OUT  = 5'd22;
    localparam logic [4:0] OP_MFHI = 5'd23;
    localparam logic [4:0] OP_MFLO = 5'd24;
    localparam logic [4:0] OP_NOP  = 5'd25;
    localparam logic [4:0] OP_HALT = 5'd26;

    // Bit positions inside ctrl; CLEAR and STROBE are reserved and held low.
    localparam int CB_RAM_READ   = 0;
    localparam int CB_RAM_WRITE  = 1;
    localparam int CB_MDR_EN     = 2;
    localparam int CB_MDR_OUT    = 3;
    localparam int CB_MAR_EN     = 4;
    localparam int CB_IR_EN      = 5;
    localparam int CB_PC_EN      = 6;
    localparam int CB_PC_OUT     = 7;
    localparam int CB_INC_PC     = 8;
    localparam int CB_Y_EN       = 9;
    localparam int CB_Z_EN       = 10;
    localparam int CB_ZLO_OUT    = 11;
    localparam int CB_ZHI_OUT    = 12;
    localparam int CB_HI_EN      = 13;
    localparam int CB_LO_EN      = 14;
    localparam int CB_HI_OUT     = 15;
    localparam int CB_LO_OUT     = 16;
    localparam int CB_GRA        = 17;
    localparam int CB_GRB        = 18;
    localparam int CB_GRC        = 19;
    localparam int CB_R_OUT      = 20;
    localparam int CB_R_EN       = 21;
    localparam int CB_C_OUT      = 22;
    localparam int CB_CON_EN     = 23;
    localparam int CB_INPORT_OUT = 24;
    localparam int CB_INPORT_EN  = 25;
    localparam int CB_OUTPORT_EN = 26;
    localparam int CB_CLEAR      = 27;
    localparam int CB_STROBE     = 28;
    localparam int CB_BA_OUT     = 29;

    typedef enum logic [3:0] {
        RESET  = 4'd0,
        FETCH0 = 4'd1,
        FETCH1 = 4'd2,
        FETCH2 = 4'd3,
        EXEC3  = 4'd4,
        EXEC4  = 4'd5,
        EXEC5  = 4'd6,
        EXEC6  = 4'd7,
        EXEC7  = 4'd8,
        HALT   = 4'd9
    } state_t;

    typedef enum logic [3:0] {
        CL_ALU, CL_IMM, CL_LDI, CL_LD, CL_ST, CL_MULDIV, CL_UNARY, CL_BR,
        CL_JR, CL_JAL, CL_IN, CL_OUT, CL_MFHI, CL_MFLO, CL_NOP, CL_HALT
    } instr_class_t;

    function automatic logic [2:0] class_last_step(input instr_class_t c);
        case (c)
            CL_LD, CL_ST:                           return 3'd7;
            CL_MULDIV, CL_BR:                       return 3'd6;
            CL_ALU, CL_IMM, CL_LDI:                 return 3'd5;
            CL_UNARY, CL_JAL:                       return 3'd4;
            CL_JR, CL_IN, CL_OUT, CL_MFHI, CL_MFLO: return 3'd3;
            default:                                return 3'd2;
        endcase
    endfunction

endpackage

// File: rtl/control_sequencer_if.sv
// Bundle between the control sequencer (master) and the datapath (slave).
interface control_sequencer_if;
    import cpu_ctrl_pkg::*;

    logic              stop;
    logic [4:0]        opcode;
    logic              con_ff;
    logic              run;
    logic [CTRL_W-1:0] ctrl;
    logic [2:0]        MDR_read;
    logic [15:0]       R0_R15_enable_in;
    logic [15:0]       R0_R15_out_in;

    modport master (
        input  stop, opcode, con_ff,
        output run, ctrl, MDR_read, R0_R15_enable_in, R0_R15_out_in
    );

    modport slave (
        output stop, opcode, con_ff,
        input  run, ctrl, MDR_read, R0_R15_enable_in, R0_R15_out_in
    );

endinterface

// File: rtl/opcode_class_decoder.sv
// Maps the 5-bit opcode onto an instruction class and the index of its final
// T-step; undefined opcodes fall into the nop class.
module opcode_class_decoder
    import cpu_ctrl_pkg::*;
(
    input  logic [4:0]   opcode,
    output instr_class_t iclass,
    output logic [2:0]   last_step
);

    always_comb begin
        iclass = CL_NOP;
        case (opcode)
            OP_ADD, OP_SUB, OP_AND, OP_OR,
            OP_SHR, OP_SHL, OP_ROR, OP_ROL: iclass = CL_ALU;
            OP_ADDI, OP_ANDI, OP_ORI:       iclass = CL_IMM;
            OP_LDI:                         iclass = CL_LDI;
            OP_LD:                          iclass = CL_LD;
            OP_ST:                          iclass = CL_ST;
            OP_MUL, OP_DIV:                 iclass = CL_MULDIV;
            OP_NEG, OP_NOT:                 iclass = CL_UNARY;
            OP_BR:                          iclass = CL_BR;
            OP_JR:                          iclass = CL_JR;
            OP_JAL:                         iclass = CL_JAL;
            OP_IN:                          iclass = CL_IN;
            OP_OUT:                         iclass = CL_OUT;
            OP_MFHI:                        iclass = CL_MFHI;
            OP_MFLO:                        iclass = CL_MFLO;
            OP_HALT:                        iclass = CL_HALT;
            default:                        iclass = CL_NOP;
        endcase
    end

    assign last_step = class_last_step(iclass);

endmodule

// File: rtl/control_sequencer.sv
// Hardwired Moore control unit for the Mini-SRC datapath: steps T0..T7 per
// instruction and decodes state plus opcode into every datapath strobe.
module control_sequencer
    import cpu_ctrl_pkg::*;
#(
    parameter logic [2:0] MDR_SEL_BUS = 3'b001,
    parameter logic [2:0] MDR_SEL_RAM = 3'b010
)(
    input logic                 clk,
    input logic                 clr,
    control_sequencer_if.master bus
);

    state_t            state;
    instr_class_t      iclass;
    logic [2:0]        last_step;
    logic [2:0]        step;
    logic              running;
    logic              at_last;
    logic [CTRL_W-1:0] ctrl_vec;
    logic [2:0]        mdr_sel;
    logic [15:0]       reg_load;

    opcode_class_decoder u_decoder (
        .opcode    (bus.opcode),
        .iclass    (iclass),
        .last_step (last_step)
    );

    always_comb begin
        step = 3'd0;
        case (state)
            FETCH1:  step = 3'd1;
            FETCH2:  step = 3'd2;
            EXEC3:   step = 3'd3;
            EXEC4:   step = 3'd4;
            EXEC5:   step = 3'd5;
            EXEC6:   step = 3'd6;
            EXEC7:   step = 3'd7;
            default: step = 3'd0;
        endcase
    end

    assign running = state inside {FETCH0, FETCH1, FETCH2, EXEC3, EXEC4, EXEC5, EXEC6, EXEC7};
    assign at_last = running && (step == last_step);

    // nop and halt end in T2, so the T2 decision uses the opcode as the IR logic presents it.
    always_ff @(posedge clk) begin
        if (!clr) begin
            state <= RESET;
        end else begin
            case (state)
                RESET:  state <= FETCH0;
                HALT:   state <= HALT;
                FETCH0: state <= FETCH1;
                FETCH1: state <= FETCH2;
                FETCH2, EXEC3, EXEC4, EXEC5, EXEC6, EXEC7: begin
                    if (at_last) begin
                        state <= (iclass == CL_HALT || bus.stop) ? HALT : FETCH0;
                    end else begin
                        case (state)
                            FETCH2:  state <= EXEC3;
                            EXEC3:   state <= EXEC4;
                            EXEC4:   state <= EXEC5;
                            EXEC5:   state <= EXEC6;
                            default: state <= EXEC7;
                        endcase
                    end
                end
                default: state <= RESET;
            endcase
        end
    end

    always_comb begin
        ctrl_vec = '0;
        mdr_sel  = 3'b000;
        reg_load = '0;
        if (running) begin
            ctrl_vec[CB_INPORT_EN] = 1'b1;
        end
        case (state)
            FETCH0: begin
                ctrl_vec[CB_PC_OUT]  = 1'b1;
                ctrl_vec[CB_MAR_EN]  = 1'b1;
                ctrl_vec[CB_INC_PC]  = 1'b1;
                ctrl_vec[CB_Z_EN]    = 1'b1;
            end
            FETCH1: begin
                ctrl_vec[CB_ZLO_OUT]  = 1'b1;
                ctrl_vec[CB_PC_EN]    = 1'b1;
                ctrl_vec[CB_RAM_READ] = 1'b1;
                ctrl_vec[CB_MDR_EN]   = 1'b1;
                mdr_sel               = MDR_SEL_RAM;
            end
            FETCH2: begin
                ctrl_vec[CB_MDR_OUT] = 1'b1;
                ctrl_vec[CB_IR_EN]   = 1'b1;
            end
            EXEC3: begin
                case (iclass)
                    CL_ALU, CL_IMM: begin
                        ctrl_vec[CB_GRB]   = 1'b1;
                        ctrl_vec[CB_R_OUT] = 1'b1;
                        ctrl_vec[CB_Y_EN]  = 1'b1;
                    end
                    CL_LDI, CL_LD, CL_ST: begin
                        ctrl_vec[CB_GRB]    = 1'b1;
                        ctrl_vec[CB_BA_OUT] = 1'b1;
                        ctrl_vec[CB_Y_EN]   = 1'b1;
                    end
                    CL_MULDIV: begin
                        ctrl_vec[CB_GRA]   = 1'b1;
                        ctrl_vec[CB_R_OUT] = 1'b1;
                        ctrl_vec[CB_Y_EN]  = 1'b1;
                    end
                    CL_UNARY: begin
                        ctrl_vec[CB_GRB]   = 1'b1;
                        ctrl_vec[CB_R_OUT] = 1'b1;
                        ctrl_vec[CB_Z_EN]  = 1'b1;
                    end
                    CL_BR: begin
                        ctrl_vec[CB_GRA]    = 1'b1;
                        ctrl_vec[CB_R_OUT]  = 1'b1;
                        ctrl_vec[CB_CON_EN] = 1'b1;
                    end
                    CL_JR: begin
                        ctrl_vec[CB_GRA]   = 1'b1;
                        ctrl_vec[CB_R_OUT] = 1'b1;
                        ctrl_vec[CB_PC_EN] = 1'b1;
                    end
                    CL_JAL: begin
                        ctrl_vec[CB_PC_OUT] = 1'b1;
                        reg_load[15]        = 1'b1;
                    end
                    CL_IN: begin
                        ctrl_vec[CB_INPORT_OUT] = 1'b1;
                        ctrl_vec[CB_GRA]        = 1'b1;
                        ctrl_vec[CB_R_EN]       = 1'b1;
                    end
                    CL_OUT: begin
                        ctrl_vec[CB_GRA]        = 1'b1;
                        ctrl_vec[CB_R_OUT]      = 1'b1;
                        ctrl_vec[CB_OUTPORT_EN] = 1'b1;
                    end
                    CL_MFHI: begin
                        ctrl_vec[CB_HI_OUT] = 1'b1;
                        ctrl_vec[CB_GRA]    = 1'b1;
                        ctrl_vec[CB_R_EN]   = 1'b1;
                    end
                    CL_MFLO: begin
                        ctrl_vec[CB_LO_OUT] = 1'b1;
                        ctrl_vec[CB_GRA]    = 1'b1;
                        ctrl_vec[CB_R_EN]   = 1'b1;
                    end
                    default: ;
                endcase
            end
            EXEC4: begin
                case (iclass)
                    CL_ALU: begin
                        ctrl_vec[CB_GRC]   = 1'b1;
                        ctrl_vec[CB_R_OUT] = 1'b1;
                        ctrl_vec[CB_Z_EN]  = 1'b1;
                    end
                    CL_IMM, CL_LDI, CL_LD, CL_ST: begin
                        ctrl_vec[CB_C_OUT] = 1'b1;
                        ctrl_vec[CB_Z_EN]  = 1'b1;
                    end
                    CL_MULDIV: begin
                        ctrl_vec[CB_GRB]   = 1'b1;
                        ctrl_vec[CB_R_OUT] = 1'b1;
                        ctrl_vec[CB_Z_EN]  = 1'b1;
                    end
                    CL_UNARY: begin
                        ctrl_vec[CB_ZLO_OUT] = 1'b1;
                        ctrl_vec[CB_GRA]     = 1'b1;
                        ctrl_vec[CB_R_EN]    = 1'b1;
                    end
                    CL_BR: begin
                        ctrl_vec[CB_PC_OUT] = 1'b1;
                        ctrl_vec[CB_Y_EN]   = 1'b1;
                    end
                    CL_JAL: begin
                        ctrl_vec[CB_GRA]   = 1'b1;
                        ctrl_vec[CB_R_OUT] = 1'b1;
                        ctrl_vec[CB_PC_EN] = 1'b1;
                    end
                    default: ;
                endcase
            end
            EXEC5: begin
                case (iclass)
                    CL_ALU, CL_IMM, CL_LDI: begin
                        ctrl_vec[CB_ZLO_OUT] = 1'b1;
                        ctrl_vec[CB_GRA]     = 1'b1;
                        ctrl_vec[CB_R_EN]    = 1'b1;
                    end
                    CL_LD, CL_ST: begin
                        ctrl_vec[CB_ZLO_OUT] = 1'b1;
                        ctrl_vec[CB_MAR_EN]  = 1'b1;
                    end
                    CL_MULDIV: begin
                        ctrl_vec[CB_ZLO_OUT] = 1'b1;
                        ctrl_vec[CB_LO_EN]   = 1'b1;
                    end
                    CL_BR: begin
                        ctrl_vec[CB_C_OUT] = 1'b1;
                        ctrl_vec[CB_Z_EN]  = 1'b1;
                    end
                    default: ;
                endcase
            end
            EXEC6: begin
                case (iclass)
                    CL_LD: begin
                        ctrl_vec[CB_RAM_READ] = 1'b1;
                        ctrl_vec[CB_MDR_EN]   = 1'b1;
                        mdr_sel               = MDR_SEL_RAM;
                    end
                    CL_ST: begin
                        ctrl_vec[CB_GRA]    = 1'b1;
                        ctrl_vec[CB_R_OUT]  = 1'b1;
                        ctrl_vec[CB_MDR_EN] = 1'b1;
                        mdr_sel             = MDR_SEL_BUS;
                    end
                    CL_MULDIV: begin
                        ctrl_vec[CB_ZHI_OUT] = 1'b1;
                        ctrl_vec[CB_HI_EN]   = 1'b1;
                    end
                    // The only Mealy path: the branch commits PC from the live CON flag.
                    CL_BR: begin
                        ctrl_vec[CB_ZLO_OUT] = 1'b1;
                        ctrl_vec[CB_PC_EN]   = bus.con_ff;
                    end
                    default: ;
                endcase
            end
            EXEC7: begin
                case (iclass)
                    CL_LD: begin
                        ctrl_vec[CB_MDR_OUT] = 1'b1;
                        ctrl_vec[CB_GRA]     = 1'b1;
                        ctrl_vec[CB_R_EN]    = 1'b1;
                    end
                    CL_ST:   ctrl_vec[CB_RAM_WRITE] = 1'b1;
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

    assign bus.run              = running;
    assign bus.ctrl             = ctrl_vec;
    assign bus.MDR_read         = mdr_sel;
    assign bus.R0_R15_enable_in = reg_load;
    assign bus.R0_R15_out_in    = '0;

endmodule

// File: tb/tb_control_sequencer.sv
// Directed self-checking bench for control_sequencer: walks reset, several
// instruction classes, stop/halt handling and reset in the middle of st.
module tb_control_sequencer;
    import cpu_ctrl_pkg::*;

    logic clk;
    logic clr;
    int   tests;
    int   failures;

    control_sequencer_if bus();

    control_sequencer dut (
        .clk (clk),
        .clr (clr),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [29:0] B_RAM_READ  = 30'd1 << CB_RAM_READ;
    localparam logic [29:0] B_RAM_WRITE = 30'd1 << CB_RAM_WRITE;
    localparam logic [29:0] B_MDR_EN    = 30'd1 << CB_MDR_EN;
    localparam logic [29:0] B_MDR_OUT   = 30'd1 << CB_MDR_OUT;
    localparam logic [29:0] B_MAR_EN    = 30'd1 << CB_MAR_EN;
    localparam logic [29:0] B_IR_EN     = 30'd1 << CB_IR_EN;
    localparam logic [29:0] B_PC_EN     = 30'd1 << CB_PC_EN;
    localparam logic [29:0] B_PC_OUT    = 30'd1 << CB_PC_OUT;
    localparam logic [29:0] B_INC_PC    = 30'd1 << CB_INC_PC;
    localparam logic [29:0] B_Y_EN      = 30'd1 << CB_Y_EN;
    localparam logic [29:0] B_Z_EN      = 30'd1 << CB_Z_EN;
    localparam logic [29:0] B_ZLO_OUT   = 30'd1 << CB_ZLO_OUT;
    localparam logic [29:0] B_ZHI_OUT   = 30'd1 << CB_ZHI_OUT;
    localparam logic [29:0] B_HI_EN     = 30'd1 << CB_HI_EN;
    localparam logic [29:0] B_LO_EN     = 30'd1 << CB_LO_EN;
    localparam logic [29:0] B_GRA       = 30'd1 << CB_GRA;
    localparam logic [29:0] B_GRB       = 30'd1 << CB_GRB;
    localparam logic [29:0] B_GRC       = 30'd1 << CB_GRC;
    localparam logic [29:0] B_R_OUT     = 30'd1 << CB_R_OUT;
    localparam logic [29:0] B_R_EN      = 30'd1 << CB_R_EN;
    localparam logic [29:0] B_C_OUT     = 30'd1 << CB_C_OUT;
    localparam logic [29:0] B_CON_EN    = 30'd1 << CB_CON_EN;
    localparam logic [29:0] B_BA_OUT    = 30'd1 << CB_BA_OUT;
    localparam logic [29:0] IPE         = 30'd1 << CB_INPORT_EN;

    localparam logic [29:0] F0_M = IPE | B_PC_OUT | B_MAR_EN | B_INC_PC | B_Z_EN;
    localparam logic [29:0] F1_M = IPE | B_ZLO_OUT | B_PC_EN | B_RAM_READ | B_MDR_EN;
    localparam logic [29:0] F2_M = IPE | B_MDR_OUT | B_IR_EN;
    localparam logic [2:0]  SEL_BUS = 3'b001;
    localparam logic [2:0]  SEL_RAM = 3'b010;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic n_clr, input logic [4:0] op,
                                 input logic stp, input logic cf);
        clr        = n_clr;
        bus.opcode = op;
        bus.stop   = stp;
        bus.con_ff = cf;
    endtask

    task automatic checkOutput(input string tag, input logic exp_run,
                               input logic [29:0] exp_ctrl, input logic [2:0] exp_mdr,
                               input logic [15:0] exp_reg_in);
        tests++;
        assert (bus.run === exp_run) else begin
            failures++;
            $display("[TB] FAIL %s run observed=%b expected=%b", tag, bus.run, exp_run);
            $error("[TB] %s run observed=%b expected=%b", tag, bus.run, exp_run);
        end
        tests++;
        assert (bus.ctrl === exp_ctrl) else begin
            failures++;
            $display("[TB] FAIL %s ctrl observed=%h expected=%h", tag, bus.ctrl, exp_ctrl);
            $error("[TB] %s ctrl observed=%h expected=%h", tag, bus.ctrl, exp_ctrl);
        end
        tests++;
        assert (bus.MDR_read === exp_mdr) else begin
            failures++;
            $display("[TB] FAIL %s MDR_read observed=%b expected=%b", tag, bus.MDR_read, exp_mdr);
            $error("[TB] %s MDR_read observed=%b expected=%b", tag, bus.MDR_read, exp_mdr);
        end
        tests++;
        assert (bus.R0_R15_enable_in === exp_reg_in) else begin
            failures++;
            $display("[TB] FAIL %s R0_R15_enable_in observed=%h expected=%h", tag, bus.R0_R15_enable_in, exp_reg_in);
            $error("[TB] %s R0_R15_enable_in observed=%h expected=%h", tag, bus.R0_R15_enable_in, exp_reg_in);
        end
        tests++;
        assert (bus.R0_R15_out_in === 16'h0000) else begin
            failures++;
            $display("[TB] FAIL %s R0_R15_out_in observed=%h expected=0000", tag, bus.R0_R15_out_in);
            $error("[TB] %s R0_R15_out_in observed=%h expected=0000", tag, bus.R0_R15_out_in);
        end
    endtask

    task automatic expectStep(input string tag, input logic [29:0] exp_ctrl,
                              input logic [2:0] exp_mdr);
        checkOutput(tag, 1'b1, exp_ctrl, exp_mdr, 16'h0000);
        tick();
    endtask

    task automatic checkFetch(input string name);
        expectStep({name, ".t0"}, F0_M, 3'b000);
        expectStep({name, ".t1"}, F1_M, SEL_RAM);
        expectStep({name, ".t2"}, F2_M, 3'b000);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        tests    = 0;
        failures = 0;

        applyStimulus(1'b0, OP_NOP, 1'b0, 1'b0);
        tick();
        checkOutput("reset0", 1'b0, '0, 3'b000, 16'h0000);
        tick();
        checkOutput("reset1", 1'b0, '0, 3'b000, 16'h0000);
        applyStimulus(1'b1, OP_ADD, 1'b0, 1'b0);
        checkOutput("reset_exit", 1'b0, '0, 3'b000, 16'h0000);
        tick();

        checkFetch("add");
        expectStep("add.t3", IPE | B_GRB | B_R_OUT | B_Y_EN, 3'b000);
        expectStep("add.t4", IPE | B_GRC | B_R_OUT | B_Z_EN, 3'b000);
        expectStep("add.t5", IPE | B_ZLO_OUT | B_GRA | B_R_EN, 3'b000);

        applyStimulus(1'b1, OP_LDI, 1'b0, 1'b0);
        checkFetch("ldi");
        expectStep("ldi.t3", IPE | B_GRB | B_BA_OUT | B_Y_EN, 3'b000);
        expectStep("ldi.t4", IPE | B_C_OUT | B_Z_EN, 3'b000);
        expectStep("ldi.t5", IPE | B_ZLO_OUT | B_GRA | B_R_EN, 3'b000);

        applyStimulus(1'b1, OP_LD, 1'b0, 1'b0);
        checkFetch("ld");
        expectStep("ld.t3", IPE | B_GRB | B_BA_OUT | B_Y_EN, 3'b000);
        expectStep("ld.t4", IPE | B_C_OUT | B_Z_EN, 3'b000);
        expectStep("ld.t5", IPE | B_ZLO_OUT | B_MAR_EN, 3'b000);
        expectStep("ld.t6", IPE | B_RAM_READ | B_MDR_EN, SEL_RAM);
        expectStep("ld.t7", IPE | B_MDR_OUT | B_GRA | B_R_EN, 3'b000);

        applyStimulus(1'b1, OP_BR, 1'b0, 1'b0);
        checkFetch("br0");
        expectStep("br0.t3", IPE | B_GRA | B_R_OUT | B_CON_EN, 3'b000);
        expectStep("br0.t4", IPE | B_PC_OUT | B_Y_EN, 3'b000);
        expectStep("br0.t5", IPE | B_C_OUT | B_Z_EN, 3'b000);
        expectStep("br0.t6", IPE | B_ZLO_OUT, 3'b000);

        applyStimulus(1'b1, OP_BR, 1'b0, 1'b1);
        checkFetch("br1");
        expectStep("br1.t3", IPE | B_GRA | B_R_OUT | B_CON_EN, 3'b000);
        expectStep("br1.t4", IPE | B_PC_OUT | B_Y_EN, 3'b000);
        expectStep("br1.t5", IPE | B_C_OUT | B_Z_EN, 3'b000);
        expectStep("br1.t6", IPE | B_ZLO_OUT | B_PC_EN, 3'b000);

        applyStimulus(1'b1, OP_JAL, 1'b0, 1'b0);
        checkFetch("jal");
        checkOutput("jal.t3", 1'b1, IPE | B_PC_OUT, 3'b000, 16'h8000);
        tick();
        expectStep("jal.t4", IPE | B_GRA | B_R_OUT | B_PC_EN, 3'b000);

        applyStimulus(1'b1, OP_MUL, 1'b0, 1'b0);
        checkFetch("mul");
        expectStep("mul.t3", IPE | B_GRA | B_R_OUT | B_Y_EN, 3'b000);
        expectStep("mul.t4", IPE | B_GRB | B_R_OUT | B_Z_EN, 3'b000);
        expectStep("mul.t5", IPE | B_ZLO_OUT | B_LO_EN, 3'b000);
        expectStep("mul.t6", IPE | B_ZHI_OUT | B_HI_EN, 3'b000);

        // stop raised at T3 is honoured only once add has finished T5
        applyStimulus(1'b1, OP_ADD, 1'b0, 1'b0);
        checkFetch("stop");
        applyStimulus(1'b1, OP_ADD, 1'b1, 1'b0);
        expectStep("stop.t3", IPE | B_GRB | B_R_OUT | B_Y_EN, 3'b000);
        expectStep("stop.t4", IPE | B_GRC | B_R_OUT | B_Z_EN, 3'b000);
        expectStep("stop.t5", IPE | B_ZLO_OUT | B_GRA | B_R_EN, 3'b000);
        checkOutput("halt", 1'b0, '0, 3'b000, 16'h0000);
        applyStimulus(1'b1, OP_ADD, 1'b0, 1'b0);
        tick();
        checkOutput("halt_hold", 1'b0, '0, 3'b000, 16'h0000);
        applyStimulus(1'b0, OP_ADD, 1'b0, 1'b0);
        tick();
        checkOutput("halt_clr", 1'b0, '0, 3'b000, 16'h0000);
        applyStimulus(1'b1, 5'b11111, 1'b0, 1'b0);
        checkOutput("halt_clr_exit", 1'b0, '0, 3'b000, 16'h0000);
        tick();

        checkFetch("undef");

        applyStimulus(1'b1, OP_ST, 1'b0, 1'b0);
        checkFetch("st");
        expectStep("st.t3", IPE | B_GRB | B_BA_OUT | B_Y_EN, 3'b000);
        expectStep("st.t4", IPE | B_C_OUT | B_Z_EN, 3'b000);
        expectStep("st.t5", IPE | B_ZLO_OUT | B_MAR_EN, 3'b000);
        expectStep("st.t6", IPE | B_GRA | B_R_OUT | B_MDR_EN, SEL_BUS);
        expectStep("st.t7", IPE | B_RAM_WRITE, 3'b000);

        applyStimulus(1'b1, OP_ST, 1'b0, 1'b0);
        checkFetch("st_abort");
        expectStep("st_abort.t3", IPE | B_GRB | B_BA_OUT | B_Y_EN, 3'b000);
        checkOutput("st_abort.t4", 1'b1, IPE | B_C_OUT | B_Z_EN, 3'b000, 16'h0000);
        applyStimulus(1'b0, OP_ST, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            tick();
            checkOutput("st_abort.rst", 1'b0, '0, 3'b000, 16'h0000);
        end
        applyStimulus(1'b1, OP_HALT, 1'b0, 1'b0);
        checkOutput("st_abort.exit", 1'b0, '0, 3'b000, 16'h0000);
        tick();

        checkFetch("halt_op");
        checkOutput("halt_op.halt", 1'b0, '0, 3'b000, 16'h0000);
        tick();
        checkOutput("halt_op.hold", 1'b0, '0, 3'b000, 16'h0000);

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
